// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply / divide unit for the execute stage. One request is
// taken over a valid/ready handshake. Multiplies run a shift-add loop
// (multiplier LSB first) and divides run a restoring loop (quotient MSB
// first), one iteration per cycle for WIDTH cycles. The result is held until
// the consumer takes it with yumi_i.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : signed_i=1 runs the loop on operand magnitudes and applies a
//               combinational sign fix-up to the selected result.
//   undefined : signed_i is ignored and every operation is unsigned.
//
// Ports
//   clk        : core clock, rising edge
//   reset      : synchronous active-high reset
//   valid_i    : request valid
//   ready_o    : unit idle, a request is accepted this cycle
//   op_i       : 00 MULLO, 01 MULHI, 10 DIV, 11 REM
//   signed_i   : two's complement operands (MULDIV_SIGNED_EN builds only)
//   rd_i       : multiplicand / dividend
//   rs_i       : multiplier / divisor
//   result_o   : result, qualified by valid_o
//   valid_o    : result available
//   yumi_i     : consumer takes the result this cycle
//   div_zero_o : result came from a DIV/REM with a zero divisor
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] rd_i,
  input  logic [WIDTH-1:0] rs_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  input  logic             yumi_i,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [1:0]         op;
  logic [CW-1:0]      cnt;
  // Multiply: multiplicand. Divide: divisor.
  logic [WIDTH-1:0]   mcand;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] acc;
  // Partial remainder; always below the divisor, so WIDTH bits hold it
  // between iterations and the WIDTH+1 bit shifted value is formed below.
  logic [WIDTH-1:0]   rem;
  logic               dz;

`ifdef MULDIV_SIGNED_EN
  logic sa;
  logic sb;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction
`endif

  // Operand magnitudes presented at accept time.
  logic [WIDTH-1:0] rd_mag;
  logic [WIDTH-1:0] rs_mag;
`ifdef MULDIV_SIGNED_EN
  logic rd_neg;
  logic rs_neg;

  always_comb begin
    rd_neg = signed_i & rd_i[WIDTH-1];
    rs_neg = signed_i & rs_i[WIDTH-1];
    rd_mag = rd_neg ? neg_w(rd_i) : rd_i;
    rs_mag = rs_neg ? neg_w(rs_i) : rs_i;
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign rd_mag        = rd_i;
  assign rs_mag        = rs_i;
`endif

  // One shift-add multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // One restoring divide step.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   q_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    // When div_ge holds the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    rem_next  = div_ge ? (div_shift[WIDTH-1:0] - mcand) : div_shift[WIDTH-1:0];
    q_next    = {acc[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op    <= 2'b00;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      rem   <= '0;
      dz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sa    <= 1'b0;
      sb    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            op  <= op_i;
            cnt <= '0;
            rem <= '0;
`ifdef MULDIV_SIGNED_EN
            sa  <= rd_neg;
            sb  <= rs_neg;
`endif
            if (op_i[1] && (rs_i == '0)) begin
              // Zero divisor: fixed answers, no iterations.
              acc   <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              rem   <= rd_i;
              mcand <= '0;
              dz    <= 1'b1;
              state <= DONE;
            end else if (op_i[1]) begin
              acc   <= {{WIDTH{1'b0}}, rd_mag};
              mcand <= rs_mag;
              dz    <= 1'b0;
              state <= BUSY;
            end else begin
              acc   <= {{WIDTH{1'b0}}, rs_mag};
              mcand <= rd_mag;
              dz    <= 1'b0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (op[1]) begin
            acc[WIDTH-1:0] <= q_next;
            rem            <= rem_next;
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (yumi_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o    = (state == IDLE);
  assign valid_o    = (state == DONE);
  assign div_zero_o = dz;

  // Result selection with optional sign fix-up. Zero-divisor answers are
  // returned exactly as latched.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;

  always_comb begin
    prod = acc;
    quo  = acc[WIDTH-1:0];
    rmd  = rem;
`ifdef MULDIV_SIGNED_EN
    if (!dz) begin
      if (sa ^ sb) begin
        prod = neg_2w(acc);
        quo  = neg_w(acc[WIDTH-1:0]);
      end
      if (sa) begin
        rmd = neg_w(rem);
      end
    end
`endif
    result_o = '0;
    case (op)
      2'b00:   result_o = prod[WIDTH-1:0];
      2'b01:   result_o = prod[2*WIDTH-1:WIDTH];
      2'b10:   result_o = quo;
      default: result_o = rmd;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit at WIDTH=32. Each request pushes its
// expected result onto a scoreboard queue; the entry is popped and compared
// when valid_o rises. Signed cases run only when MULDIV_SIGNED_EN is defined;
// otherwise the bench confirms signed_i is ignored.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   op_i;
  logic         signed_i;
  logic [W-1:0] rd_i;
  logic [W-1:0] rs_i;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         yumi_i;
  logic         div_zero_o;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .signed_i   (signed_i),
    .rd_i       (rd_i),
    .rs_i       (rs_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .yumi_i     (yumi_i),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model. lat is the number of rising edges after the accept
  // edge before valid_o is seen high (0: visible right after accept).
  function automatic exp_t model(input logic [1:0] o, input logic sgn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic        s;
    logic [63:0] p;
    int          sa_;
    int          sb_;
    s     = sgn & SIGNED_BUILD;
    e.dz  = 1'b0;
    e.lat = W;
    e.res = '0;
    if (!o[1]) begin
      if (s) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else   p = {32'b0, a} * {32'b0, b};
      e.res = o[0] ? p[63:32] : p[31:0];
    end else if (b == 0) begin
      e.dz  = 1'b1;
      e.lat = 0;
      e.res = o[0] ? a : 32'hFFFF_FFFF;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.res = o[0] ? 32'h0 : 32'h8000_0000;
      end else begin
        sa_   = a;
        sb_   = b;
        e.res = o[0] ? sa_ % sb_ : sa_ / sb_;
      end
    end else begin
      e.res = o[0] ? a % b : a / b;
    end
    return e;
  endfunction

  // Drive one request; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    while (!ready_o && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    valid_i  = 1'b1;
    op_i     = o;
    signed_i = sgn;
    rd_i     = a;
    rs_i     = b;
    @(posedge clk); #1;
    valid_i  = 1'b0;
  endtask

  // Bounded wait for valid_o; lat = -1 when the bound expires.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid_o) lat = -1;
  endtask

  task automatic take();
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid_i  = 1'b0;
    yumi_i   = 1'b0;
    op_i     = 2'b00;
    signed_i = 1'b0;
    rd_i     = '0;
    rs_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready_o); end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    n_tests++; if (div_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b want=0", div_zero_o); end
    n_tests++; if (result_o !== '0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result_o); end
  endtask

  task automatic test_mul();
    for (int i = 0; i < 6; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      exp_t         e;
      int           lat;
      if (i < 2) begin
        o = 2'(i); a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        e.res = (i == 0) ? 32'h0000_0001 : 32'hFFFF_FFFE; e.dz = 1'b0; e.lat = W;
      end else begin
        o = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom;
        e = model(o, 1'b0, a, b);
      end
      sb.push_back(e);
      issue(o, 1'b0, a, b);
      wait_valid(lat);
      e = sb.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL mul_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL mul_result[%0d] got=%h want=%h", i, result_o, e.res); end
      n_tests++; if (div_zero_o !== e.dz) begin n_fail++; $display("FAIL mul_dz[%0d] got=%b want=%b", i, div_zero_o, e.dz); end
      take();
    end
  endtask

  task automatic test_div();
    for (int i = 0; i < 7; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      exp_t         e;
      int           lat;
      if (i < 2) begin
        o = (i == 0) ? 2'b10 : 2'b11; a = 100; b = 7;
        e.res = (i == 0) ? 32'd14 : 32'd2; e.dz = 1'b0; e.lat = W;
      end else begin
        o = 2'($urandom_range(2, 3)); a = $urandom;
        b = (i < 5) ? 32'($urandom_range(1, 1000)) : $urandom;
        if (b == 0) b = 1;
        e = model(o, 1'b0, a, b);
      end
      sb.push_back(e);
      issue(o, 1'b0, a, b);
      wait_valid(lat);
      e = sb.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL div_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL div_result[%0d] got=%h want=%h", i, result_o, e.res); end
      n_tests++; if (div_zero_o !== e.dz) begin n_fail++; $display("FAIL div_dz[%0d] got=%b want=%b", i, div_zero_o, e.dz); end
      take();
    end
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 2; i++) begin
      logic [1:0] o;
      exp_t       e;
      int         lat;
      o     = (i == 0) ? 2'b10 : 2'b11;
      e.res = (i == 0) ? 32'hFFFF_FFFF : 32'd5;
      e.dz  = 1'b1;
      e.lat = 0;
      sb.push_back(e);
      issue(o, 1'b0, 32'd5, 32'd0);
      wait_valid(lat);
      e = sb.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL dz_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL dz_result[%0d] got=%h want=%h", i, result_o, e.res); end
      n_tests++; if (div_zero_o !== e.dz) begin n_fail++; $display("FAIL dz_flag[%0d] got=%b want=%b", i, div_zero_o, e.dz); end
      take();
    end
  endtask

  // Signed builds: signed arithmetic. Unsigned builds: signed_i=1 must not
  // change anything.
  task automatic test_signed();
    logic [1:0]   ops [4];
    logic [W-1:0] as  [4];
    logic [W-1:0] bs  [4];
    logic [W-1:0] rs  [4];
`ifdef MULDIV_SIGNED_EN
    ops = '{2'b10, 2'b11, 2'b10, 2'b01};
    as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    bs  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd1};
    rs  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
`else
    ops = '{2'b10, 2'b11, 2'b01, 2'b00};
    as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs  = '{32'd2, 32'd2, 32'd1, 32'hFFFF_FFFF};
    rs  = '{32'h7FFF_FFFC, 32'd1, 32'd0, 32'd1};
`endif
    for (int i = 0; i < 8; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      exp_t         e;
      int           lat;
      if (i < 4) begin
        o = ops[i]; a = as[i]; b = bs[i];
        e.res = rs[i]; e.dz = 1'b0; e.lat = W;
      end else begin
        o = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        if (b == 0) b = 32'hFFFF_FFF0;
        e = model(o, 1'b1, a, b);
      end
      sb.push_back(e);
      issue(o, 1'b1, a, b);
      wait_valid(lat);
      e = sb.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL sgn_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL sgn_result[%0d] got=%h want=%h", i, result_o, e.res); end
      n_tests++; if (div_zero_o !== e.dz) begin n_fail++; $display("FAIL sgn_dz[%0d] got=%b want=%b", i, div_zero_o, e.dz); end
      take();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    e.res = 32'h0123_4500; e.dz = 1'b0; e.lat = W;
    sb.push_back(e);
    issue(2'b00, 1'b0, 32'h0001_2345, 32'h0000_0100);
    wait_valid(lat);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL bp_latency got=%0d want=%0d", lat, e.lat); end
    n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL bp_result got=%h want=%h", result_o, e.res); end
    // A competing request is held while the result waits.
    valid_i = 1'b1; op_i = 2'b10; signed_i = 1'b0; rd_i = 32'd1000; rs_i = 32'd10;
    sb.push_back(model(2'b10, 1'b0, 32'd1000, 32'd10));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, valid_o); end
      n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d] got=%b want=0", i, ready_o); end
      n_tests++; if (result_o !== 32'h0123_4500) begin n_fail++; $display("FAIL bp_hold_result[%0d] got=%h want=01234500", i, result_o); end
    end
    take();
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_yumi got=%b want=1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_held_accept got=%b want=0", ready_o); end
    wait_valid(lat);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL bp2_latency got=%0d want=%0d", lat, e.lat); end
    n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL bp2_result got=%h want=%h", result_o, e.res); end
    take();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat;
    int   seen;
    issue(2'b10, 1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b want=0", valid_o); end
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got=%b want=1", ready_o); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_result got=%0d want=0 valid cycles", seen); end
    e.res = 32'd12; e.dz = 1'b0; e.lat = W;
    sb.push_back(e);
    issue(2'b00, 1'b0, 32'd3, 32'd4);
    wait_valid(lat);
    e = sb.pop_front();
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL rmid_latency got=%0d want=%0d", lat, e.lat); end
    n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL rmid_result got=%h want=%h", result_o, e.res); end
    take();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [1:0]   o;
      logic         s;
      logic [W-1:0] a, b;
      exp_t         e;
      int           lat;
      o = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom;
      e = model(o, s, a, b);
      sb.push_back(e);
      issue(o, s, a, b);
      wait_valid(lat);
      e = sb.pop_front();
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, lat, e.lat); end
      n_tests++; if (result_o !== e.res) begin n_fail++; $display("FAIL b2b_result[%0d] got=%h want=%h", i, result_o, e.res); end
      n_tests++; if (div_zero_o !== e.dz) begin n_fail++; $display("FAIL b2b_dz[%0d] got=%b want=%b", i, div_zero_o, e.dz); end
      take();
      n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, ready_o); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
